// File: rtl/cmd_daisy_router.sv
// cmd_daisy_router: buffers valid-only command pulses and dispatches them to the local or forward AXI-Stream port by address.
module cmd_daisy_router #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [7:0]  MY_ADDR    = 8'h00,
    parameter logic [7:0]  BCAST_ADDR = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           cmd_TDATA,
    input  logic                  cmd_TVALID,
    output logic [55:0]           local_TDATA,
    output logic                  local_TVALID,
    input  logic                  local_TREADY,
    output logic [63:0]           fwd_TDATA,
    output logic                  fwd_TVALID,
    input  logic                  fwd_TREADY,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fill_level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LOCAL, FWD, BCAST} state_t;

    state_t              state_q, state_d;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]         mem_q [DEPTH];
    logic [63:0]         mem_d [DEPTH];
    logic [63:0]         cmd_q, cmd_d;
    logic                local_valid_q, local_valid_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic                overflow_q, overflow_d;
    logic                full, empty, push, pop;
    logic [63:0]         head;

    // The extra pointer MSB makes full and empty distinguishable after wrap-around.
    assign fill_level   = wr_ptr_q - rd_ptr_q;
    assign full         = fill_level == (DEPTH_LOG2 + 1)'(DEPTH);
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign head         = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign push         = cmd_TVALID && !full;
    assign pop          = (state_q == IDLE) && !empty;
    assign local_TDATA  = cmd_q[55:0];
    assign fwd_TDATA    = cmd_q;
    assign local_TVALID = local_valid_q;
    assign fwd_TVALID   = fwd_valid_q;
    assign overflow     = overflow_q;

    // FIFO write/read pointers and storage; fullness is judged before any same-cycle pop.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = cmd_TDATA;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | (cmd_TVALID & full);
    end

    // Dispatch FSM: pop in IDLE, then hold the registered command until each target port accepts.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        local_valid_d = local_valid_q;
        fwd_valid_d   = fwd_valid_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    cmd_d = head;
                    if (head[63:56] == BCAST_ADDR) begin
                        state_d       = BCAST;
                        local_valid_d = 1'b1;
                        fwd_valid_d   = 1'b1;
                    end else if (head[63:56] == MY_ADDR) begin
                        state_d       = LOCAL;
                        local_valid_d = 1'b1;
                    end else begin
                        state_d     = FWD;
                        fwd_valid_d = 1'b1;
                    end
                end
            end
            LOCAL: begin
                if (local_TREADY) begin
                    local_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            FWD: begin
                if (fwd_TREADY) begin
                    fwd_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            BCAST: begin
                local_valid_d = local_valid_q & ~local_TREADY;
                fwd_valid_d   = fwd_valid_q & ~fwd_TREADY;
                if (!local_valid_d && !fwd_valid_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; an asserted reset discards queued and in-flight commands at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cmd_q         <= '0;
            local_valid_q <= 1'b0;
            fwd_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cmd_q         <= cmd_d;
            local_valid_q <= local_valid_d;
            fwd_valid_q   <= fwd_valid_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
        end
    end

endmodule
